// File: rtl/sipo_deser.sv
// Serial-in / parallel-out deserializer with a one-deep output holding register and ready/valid handoff.
// Define SIPO_DESER_PARITY_EN to expect a trailing even-parity bit per frame.
module sipo_deser #(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         serial_in,
  input  logic                         in_valid,
  input  logic                         frame_start,
  output logic [WIDTH-1:0]             parallel_out,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(WIDTH+2)-1:0]   bit_count,
  output logic                         overrun,
  output logic                         parity_err
);

  // Output handshake: a word transfers on any edge where out_valid && out_ready.
  // out_valid never drops without that transfer; out_ready is ignored while out_valid is low.
  localparam int CW = $clog2(WIDTH+2);
`ifdef SIPO_DESER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(FRAME_LEN - 1);
  localparam logic [CW-1:0] DATA_LEN = CW'(WIDTH);

  logic [WIDTH-1:0] shift_q, shift_base, shift_d, word_d;
  logic [CW-1:0]    count_q, count_base, count_d;
  logic             word_done;
  logic             take_word;

  // frame_start realigns before the current bit is considered, so that bit becomes bit 1.
  always_comb begin
    shift_base = frame_start ? '0 : shift_q;
    count_base = frame_start ? '0 : count_q;
    shift_d    = shift_base;
    count_d    = count_base;
    word_d     = '0;
    word_done  = 1'b0;
    if (in_valid) begin
      if (count_base < DATA_LEN) begin
        if (MSB_FIRST) shift_d = {shift_base[WIDTH-2:0], serial_in};
        else           shift_d = {serial_in, shift_base[WIDTH-1:1]};
      end
      word_d = shift_d;
      if (count_base == LAST_IDX) begin
        word_done = 1'b1;
        count_d   = '0;
        shift_d   = '0;
      end else begin
        count_d = count_base + 1'b1;
      end
    end
  end

  // A completed word is taken if the holding register is empty or being drained this edge.
  assign take_word = word_done && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q      <= '0;
      count_q      <= '0;
      parallel_out <= '0;
      out_valid    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      shift_q <= shift_d;
      count_q <= count_d;
      if (take_word) begin
        parallel_out <= word_d;
        out_valid    <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      if (word_done && out_valid && !out_ready)
        overrun <= 1'b1;
    end
  end

  assign bit_count = count_q;

`ifdef SIPO_DESER_PARITY_EN
  logic par_q, par_base, par_d, perr_d;

  // Running XOR of the data bits; the last frame bit is the parity bit itself.
  always_comb begin
    par_base = frame_start ? 1'b0 : par_q;
    par_d    = par_base;
    perr_d   = par_base ^ serial_in;
    if (in_valid) par_d = word_done ? 1'b0 : (par_base ^ serial_in);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_q      <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_q <= par_d;
      if (take_word) parity_err <= perr_d;
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: MSB-first and LSB-first instances share stimulus; a queue-based
// frame model predicts word, handshake, bit count and overrun after every clock.
module tb_sipo_deser;
  localparam int W  = 8;
  localparam int CW = $clog2(W+2);

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic serial_in = 1'b0, in_valid = 1'b0, frame_start = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  po_m, po_l;
  logic          ov_m, ov_l, orun_m, orun_l, pe_m, pe_l;
  logic [CW-1:0] bc_m, bc_l;

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .frame_start(frame_start), .parallel_out(po_m), .out_valid(ov_m),
    .out_ready(out_ready), .bit_count(bc_m), .overrun(orun_m), .parity_err(pe_m)
  );

  sipo_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .in_valid(in_valid),
    .frame_start(frame_start), .parallel_out(po_l), .out_valid(ov_l),
    .out_ready(out_ready), .bit_count(bc_l), .overrun(orun_l), .parity_err(pe_l)
  );

  // scoreboard state
  int n_vec  = 0;
  int n_fail = 0;
  logic         frame_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_word_m = '0, m_word_l = '0;
  logic         m_valid = 1'b0, m_overrun = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".po_msb"},  64'(po_m),   64'(m_word_m));
    chk({tag, ".po_lsb"},  64'(po_l),   64'(m_word_l));
    chk({tag, ".ov_msb"},  64'(ov_m),   64'(m_valid));
    chk({tag, ".ov_lsb"},  64'(ov_l),   64'(m_valid));
    chk({tag, ".bc_msb"},  64'(bc_m),   64'(frame_q.size()));
    chk({tag, ".bc_lsb"},  64'(bc_l),   64'(frame_q.size()));
    chk({tag, ".orun"},    64'(orun_m), 64'(m_overrun));
    chk({tag, ".orun_l"},  64'(orun_l), 64'(m_overrun));
    chk({tag, ".perr"},    64'(pe_m | pe_l), 64'd0);
  endtask

  task automatic model_reset();
    frame_q.delete();
    m_word_m  = '0;
    m_word_l  = '0;
    m_valid   = 1'b0;
    m_overrun = 1'b0;
  endtask

  // driver: one clock of stimulus, model update, then check after the edge
  task automatic step(input logic sin, input logic iv, input logic fs, input logic ordy);
    logic [W-1:0] wm, wl;
    logic done, consume;
    @(negedge clk);
    serial_in = sin; in_valid = iv; frame_start = fs; out_ready = ordy;
    done    = 1'b0;
    wm      = '0;
    wl      = '0;
    consume = m_valid && ordy;
    if (fs) frame_q.delete();
    if (iv) begin
      frame_q.push_back(sin);
      if (frame_q.size() == W) begin
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = frame_q[i];
          wl[i]     = frame_q[i];
        end
        done = 1'b1;
        frame_q.delete();
      end
    end
    if (done && (!m_valid || ordy)) begin
      m_word_m = wm; m_word_l = wl; m_valid = 1'b1;
    end else if (done) begin
      m_overrun = 1'b1;
    end else if (consume) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all("step");
  endtask

  task automatic send_word(input logic [W-1:0] w, input logic ordy);
    for (int i = W-1; i >= 0; i--) step(w[i], 1'b1, 1'b0, ordy);
  endtask

  initial begin
    logic [W-1:0] rw;
    // reset state, asynchronous: checked before any clock edge
    #2;
    check_all("reset");
    chk("reset.po", 64'(po_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // known stream 1,0,1,1,0,0,1,0 with consumer ready
    send_word(8'hB2, 1'b1);
    chk("b2.msb", 64'(po_m), 64'hB2);
    chk("b2.lsb", 64'(po_l), 64'h4D);
    chk("b2.valid", 64'(ov_m), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2.one_cycle", 64'(ov_m), 64'd0);

    // stalled consumer: second word dropped, overrun sticky
    send_word(8'hB2, 1'b0);
    send_word(8'h11, 1'b0);
    chk("ovr.hold", 64'(po_m), 64'hB2);
    chk("ovr.flag", 64'(orun_m), 64'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("ovr.drained", 64'(ov_m), 64'd0);
    chk("ovr.sticky", 64'(orun_m), 64'd1);

    // frame_start with a bit: partial frame of 5 discarded
    for (int i = 0; i < 5; i++) step(1'($urandom_range(0, 1)), 1'b1, 1'b0, 1'b1);
    rw = 8'h5C;
    step(rw[7], 1'b1, 1'b1, 1'b1);
    chk("fs.count", 64'(bc_m), 64'd1);
    for (int i = 6; i >= 0; i--) step(rw[i], 1'b1, 1'b0, 1'b1);
    chk("fs.word", 64'(po_m), 64'h5C);
    chk("fs.valid", 64'(ov_m), 64'd1);

    // randomized traffic with occasional realign and back-pressure
    for (int n = 0; n < 400; n++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 19) == 0), 1'($urandom_range(0, 3) != 0));

    // reset mid-frame while a word is held
    send_word(8'hA7, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; frame_start = 1'b0; out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    chk("arst.count", 64'(bc_m), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send_word(8'hC5, 1'b1);
    chk("post_rst.msb", 64'(po_m), 64'hC5);
    chk("post_rst.lsb", 64'(po_l), 64'hA3);
    chk("post_rst.orun", 64'(orun_m), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
